addsub_seq: RTL

Parametrised multi-cycle two's-complement add/subtract unit for the Y86 ALU path. It processes a WIDTH-bit operand pair CHUNK bits per cycle, least-significant chunk first, with the carry held in a register between chunks. It returns the result together with Y86-style condition flags (ZF, SF, OF) and the raw carry-out (CF). Operands arrive and results leave over valid/ready handshakes, so the unit can sit between the execute-stage operand latch and the condition-code register.

---
 rtl/addsub_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement add/subtract: CHUNK bits per cycle, LSB chunk first,
// with Y86-style condition flags registered alongside the final chunk.
module addsub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cf,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [KW-1:0]    k;

    logic [CHUNK:0]   chunk_sum;
    logic [31:0]      shamt;
    logic [WIDTH-1:0] chunk_mask;
    logic [WIDTH-1:0] result_next;
    logic             last;

    // Operand registers shift right each RUN cycle, so the active chunk always
    // sits in the low CHUNK bits; on the last chunk bit CHUNK-1 is the sign bit.
    always_comb begin
        chunk_sum   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry);
        shamt       = 32'(k) * CHUNK;
        chunk_mask  = WIDTH'({CHUNK{1'b1}}) << shamt;
        result_next = (result & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);
    end

    assign last = (k == KW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            zf        <= 1'b0;
            sf        <= 1'b0;
            of        <= 1'b0;
            cf        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= op ? ~b : b;
                        carry    <= op;
                        k        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    result <= result_next;
                    carry  <= chunk_sum[CHUNK];
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    k      <= k + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        cf        <= chunk_sum[CHUNK];
                        zf        <= (result_next == '0);
                        sf        <= result_next[WIDTH-1];
                        of        <= (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                                     (result_next[WIDTH-1] != a_q[CHUNK-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
